// File: rtl/crc16_arbiter.sv
// Shares one crc16_engine between the CPU MMIO bridge and the seal requester.
// Optional build macro CRC16_CTX_SAVE_EN saves/restores the CPU's CRC across a seal grant.
module crc16_arbiter #(
  parameter int CPU_HOLD = 16,
  parameter int SEAL_MAX = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_init,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_data_valid,
  output logic        cpu_busy,
  output logic [15:0] cpu_crc,
  input  logic        seal_req,
  output logic        seal_grant,
  input  logic [7:0]  seal_data,
  input  logic        seal_valid,
  output logic        seal_ready,
  output logic [15:0] seal_crc,
  output logic        eng_init,
  output logic [7:0]  eng_data,
  output logic        eng_data_valid,
  input  logic [15:0] eng_crc,
  input  logic        eng_busy
`ifdef CRC16_CTX_SAVE_EN
  ,
  output logic        eng_load,
  output logic [15:0] eng_load_value
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_CPU, S_DRAIN, S_SEAL_INIT, S_SEAL, S_RELEASE
  } state_t;

  localparam logic [7:0] HOLD_LD = 8'(CPU_HOLD);
  localparam logic [7:0] MAX_B   = 8'(SEAL_MAX);

  state_t      state, state_nxt;
  logic [7:0]  hold_cnt, hold_nxt;
  logic [7:0]  byte_cnt, byte_nxt;
  logic        cpu_pulse;
  logic        grant_c, ready_c, init_c, dv_c;
  logic [7:0]  data_c;

  assign cpu_pulse = cpu_init | cpu_data_valid;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    byte_nxt  = byte_cnt;
    grant_c   = 1'b0;
    ready_c   = 1'b0;
    init_c    = 1'b0;
    dv_c      = 1'b0;
    data_c    = 8'h00;
    case (state)
      S_IDLE, S_CPU: begin
        // CPU pulses go straight through; a same-cycle seal_req loses to them
        if (cpu_pulse) begin
          init_c    = cpu_init;
          dv_c      = cpu_data_valid & ~cpu_init;
          data_c    = (cpu_data_valid & ~cpu_init) ? cpu_data : 8'h00;
          hold_nxt  = HOLD_LD;
          state_nxt = S_CPU;
        end else if (state == S_CPU) begin
          hold_nxt = (hold_cnt != 8'd0) ? hold_cnt - 8'd1 : 8'd0;
          if (hold_cnt <= 8'd1) state_nxt = S_IDLE;
        end else if (seal_req) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        grant_c = 1'b1;
        if (!eng_busy) state_nxt = S_SEAL_INIT;
      end
      S_SEAL_INIT: begin
        // init always completes so the engine is never left half-owned
        grant_c   = 1'b1;
        init_c    = 1'b1;
        byte_nxt  = 8'd0;
        state_nxt = seal_req ? S_SEAL : S_RELEASE;
      end
      S_SEAL: begin
        grant_c = 1'b1;
        ready_c = !eng_busy && (byte_cnt < MAX_B);
        if (ready_c && seal_valid) begin
          dv_c     = 1'b1;
          data_c   = seal_data;
          byte_nxt = byte_cnt + 8'd1;
        end
        if (!seal_req || (byte_cnt == MAX_B && !eng_busy)) state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        grant_c = 1'b1;
        if (!eng_busy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      hold_cnt <= 8'd0;
      byte_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      byte_cnt <= byte_nxt;
    end
  end

  // rst gates the combinational path so CPU pulses cannot leak through during reset
  assign seal_grant     = grant_c & ~rst;
  assign seal_ready     = ready_c & ~rst;
  assign eng_init       = init_c & ~rst;
  assign eng_data_valid = dv_c & ~rst;
  assign eng_data       = rst ? 8'h00 : data_c;
  assign cpu_busy       = eng_busy | (state == S_DRAIN) | (state == S_SEAL_INIT) |
                          (state == S_SEAL) | (state == S_RELEASE);
  assign cpu_crc        = eng_crc;
  assign seal_crc       = eng_crc;

`ifdef CRC16_CTX_SAVE_EN
  logic [15:0] ctx_reg;

  // engine is idle on the DRAIN exit cycle, so the last latched value is final
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  ctx_reg <= 16'h0000;
    else if (state == S_DRAIN) ctx_reg <= eng_crc;
  end

  assign eng_load       = ~rst & (state == S_RELEASE) & ~eng_busy;
  assign eng_load_value = ctx_reg;
`endif

endmodule

// File: tb/tb_crc16_arbiter.sv
// Bench for crc16_arbiter with a behavioural CRC-16/CCITT-FALSE engine and a byte scoreboard.
module tb_crc16_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_init, cpu_data_valid, seal_req, seal_valid;
  logic [7:0]  cpu_data, seal_data;
  logic        cpu_busy, seal_grant, seal_ready, eng_init, eng_data_valid, eng_busy;
  logic [15:0] cpu_crc, seal_crc, eng_crc;
  logic [7:0]  eng_data;
`ifdef CRC16_CTX_SAVE_EN
  logic        eng_load;
  logic [15:0] eng_load_value;
`endif

  always #5 clk = ~clk;

  crc16_arbiter #(.CPU_HOLD(16), .SEAL_MAX(10)) dut (
    .clk(clk), .rst(rst),
    .cpu_init(cpu_init), .cpu_data(cpu_data), .cpu_data_valid(cpu_data_valid),
    .cpu_busy(cpu_busy), .cpu_crc(cpu_crc),
    .seal_req(seal_req), .seal_grant(seal_grant), .seal_data(seal_data),
    .seal_valid(seal_valid), .seal_ready(seal_ready), .seal_crc(seal_crc),
    .eng_init(eng_init), .eng_data(eng_data), .eng_data_valid(eng_data_valid),
    .eng_crc(eng_crc), .eng_busy(eng_busy)
`ifdef CRC16_CTX_SAVE_EN
    , .eng_load(eng_load), .eng_load_value(eng_load_value)
`endif
  );

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  // engine model: one byte per accept, then busy for three cycles
  logic [15:0] m_crc;
  logic [1:0]  m_bcnt;
  assign eng_crc  = m_crc;
  assign eng_busy = (m_bcnt != 2'd0);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_crc  <= 16'hFFFF;
      m_bcnt <= 2'd0;
    end else begin
      if (m_bcnt != 2'd0) m_bcnt <= m_bcnt - 2'd1;
      if (eng_init) m_crc <= 16'hFFFF;
      else if (eng_data_valid) begin
        m_crc  <= crc_byte(m_crc, eng_data);
        m_bcnt <= 2'd3;
      end
`ifdef CRC16_CTX_SAVE_EN
      else if (eng_load) m_crc <= eng_load_value;
`endif
    end
  end

  int pass_cnt = 0, total_cnt = 0;
  int load_cnt = 0;
  bit grant_seen = 0;
  logic [7:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // scoreboard pop: every byte reaching the engine must have been expected
  always @(negedge clk) begin
    #4;
    if (!rst) begin
      if (seal_grant) grant_seen = 1;
`ifdef CRC16_CTX_SAVE_EN
      if (eng_load) load_cnt++;
`endif
      if (eng_init) chk("init_excl_valid", eng_data_valid, 1'b0);
      if (eng_data_valid) begin
        if (sb.size() == 0) chk("sb_unexpected_byte", {24'h0, eng_data}, 32'hFFFF_FFFF);
        else chk("sb_byte", eng_data, sb.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic wait_engine();
    int n = 0;
    while (eng_busy && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("busy_timeout", eng_busy, 1'b0);
  endtask

  task automatic cpu_init_pulse();
    @(negedge clk); wait_engine();
    cpu_init = 1'b1;
    @(negedge clk); cpu_init = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] b);
    @(negedge clk); wait_engine();
    cpu_data = b; cpu_data_valid = 1'b1; sb.push_back(b);
    @(negedge clk); cpu_data_valid = 1'b0;
  endtask

  task automatic seal_byte(input logic [7:0] b);
    bit ok = 0;
    @(negedge clk);
    seal_data = b; seal_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (seal_ready) begin sb.push_back(b); ok = 1; break; end
      @(negedge clk);
    end
    chk("seal_handshake", ok, 1'b1);
    @(negedge clk); seal_valid = 1'b0;
  endtask

  task automatic wait_grant(input logic v);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if (seal_grant === v) break;
    end
    chk("grant_wait", seal_grant, v);
  endtask

  typedef struct {
    logic ci; logic cv; logic [7:0] d;
    logic e_init; logic e_dv; logic [7:0] e_d;
  } vec_t;
  vec_t tbl[6];

  logic [15:0] exp_crc;
  int low, hs, cap;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 8'h31, 1'b0, 1'b1, 8'h31};
    tbl[2] = '{1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 1'b1, 8'h42, 1'b1, 1'b0, 8'h00};
    tbl[5] = '{1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'hC3};

    // reset: a CPU pulse held during reset must not reach the engine
    rst = 1'b1; cpu_init = 1'b0; cpu_data = 8'h99; cpu_data_valid = 1'b1;
    seal_req = 1'b0; seal_data = 8'h00; seal_valid = 1'b0;
    #1;
    chk("rst_grant", seal_grant, 1'b0);
    chk("rst_ready", seal_ready, 1'b0);
    chk("rst_eng_init", eng_init, 1'b0);
    chk("rst_eng_dv", eng_data_valid, 1'b0);
    chk("rst_eng_data", eng_data, 8'h00);
    chk("rst_cpu_busy", cpu_busy, 1'b0);
    chk("rst_cpu_crc", cpu_crc, 16'hFFFF);
    @(negedge clk); rst = 1'b0; cpu_data_valid = 1'b0;

    // forwarding table in IDLE/CPU ownership
    foreach (tbl[i]) begin
      @(negedge clk);
      cpu_init = tbl[i].ci; cpu_data_valid = tbl[i].cv; cpu_data = tbl[i].d;
      if (tbl[i].e_dv) sb.push_back(tbl[i].d);
      #1;
      chk($sformatf("tbl%0d_init", i), eng_init, tbl[i].e_init);
      chk($sformatf("tbl%0d_dv", i), eng_data_valid, tbl[i].e_dv);
      chk($sformatf("tbl%0d_data", i), eng_data, tbl[i].e_d);
      chk($sformatf("tbl%0d_grant", i), seal_grant, 1'b0);
    end
    @(negedge clk); cpu_init = 1'b0; cpu_data_valid = 1'b0;
    repeat (20) @(negedge clk);

    // CPU computes "123456789"
    grant_seen = 0;
    cpu_init_pulse();
    for (int i = 0; i < 9; i++) cpu_write(8'h31 + 8'(i));
    @(negedge clk); wait_engine(); #1;
    chk("cpu_check_crc", cpu_crc, 16'h29B1);
    chk("cpu_no_grant", grant_seen, 1'b0);
    repeat (20) @(negedge clk);

    // seal from IDLE: grant next cycle, init one cycle later, then bytes
    exp_crc = m_crc;
    seal_req = 1'b1; #1;
    chk("s2_grant_idle", seal_grant, 1'b0);
    @(negedge clk); #1;
    chk("s2_grant_drain", seal_grant, 1'b1);
    chk("s2_init_drain", eng_init, 1'b0);
    chk("s2_cpu_busy", cpu_busy, 1'b1);
    @(negedge clk); #1;
    chk("s2_init_pulse", eng_init, 1'b1);
    @(negedge clk); #1;
    chk("s2_init_done", eng_init, 1'b0);
    chk("s2_ready", seal_ready, 1'b1);
    for (int i = 0; i < 9; i++) seal_byte(8'h31 + 8'(i));
    @(negedge clk); wait_engine(); #1;
    chk("s2_ready_end", seal_ready, 1'b1);
    chk("s2_seal_crc", seal_crc, 16'h29B1);
    seal_req = 1'b0;
    @(negedge clk); #1;
    chk("s2_grant_release", seal_grant, 1'b1);
`ifdef CRC16_CTX_SAVE_EN
    chk("s2_eng_load", eng_load, 1'b1);
    chk("s2_load_value", eng_load_value, exp_crc);
`endif
    @(negedge clk); #1;
    chk("s2_grant_low", seal_grant, 1'b0);
`ifdef CRC16_CTX_SAVE_EN
    chk("s2_crc_after", cpu_crc, exp_crc);
`else
    chk("s2_crc_after", cpu_crc, 16'h29B1);
`endif
    repeat (20) @(negedge clk);

    // same-cycle CPU byte and seal_req: CPU wins, seal waits out the hold
    cpu_data = 8'h5A; cpu_data_valid = 1'b1; seal_req = 1'b1; sb.push_back(8'h5A);
    #1;
    chk("s4_fwd_dv", eng_data_valid, 1'b1);
    chk("s4_fwd_data", eng_data, 8'h5A);
    chk("s4_grant", seal_grant, 1'b0);
    // 16 idle CPU cycles plus the IDLE arbitration cycle before DRAIN
    low = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); cpu_data_valid = 1'b0; #1;
      if (seal_grant) break;
      low++;
    end
    chk("s3_hold_lapse", low, 17);
    cpu_data = 8'hEE; cpu_data_valid = 1'b1; #1;
    chk("s3_drain_drop", eng_data_valid, 1'b0);
    chk("s3_drain_busy", cpu_busy, 1'b1);
    @(negedge clk); #1;
    chk("s3_init_pulse", eng_init, 1'b1);
    chk("s3_init_drop", eng_data_valid, 1'b0);
    @(negedge clk); #1;
    chk("s3_seal_drop", eng_data_valid, 1'b0);
    chk("s3_seal_busy", cpu_busy, 1'b1);
    chk("s3_seal_ready", seal_ready, 1'b1);
    cpu_data_valid = 1'b0;
    seal_byte(8'hA1);
    seal_byte(8'hA2);
    @(negedge clk); seal_req = 1'b0;
    wait_grant(1'b0);
    repeat (20) @(negedge clk);

    // byte cap: valid held high, grant ends after SEAL_MAX handshakes
    hs = 0; cap = 0;
    seal_req = 1'b1; seal_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      seal_data = 8'h40 + 8'(hs);
      #1;
      if (!seal_grant) break;
      if (seal_ready) begin sb.push_back(seal_data); hs++; end
      else if (hs == 10) cap++;
    end
    seal_req = 1'b0; seal_valid = 1'b0;
    chk("s5_grant_ended", seal_grant, 1'b0);
    chk("s5_handshakes", hs, 10);
    chk("s5_cap_ready_low", cap != 0, 1'b1);
    chk("s5_ready_idle", seal_ready, 1'b0);
    repeat (20) @(negedge clk);

    // CPU "1234", seal "AB", CPU "56789"
    load_cnt = 0;
    cpu_init_pulse();
    for (int i = 0; i < 4; i++) cpu_write(8'h31 + 8'(i));
    @(negedge clk); seal_req = 1'b1;
    seal_byte(8'h41);
    seal_byte(8'h42);
    @(negedge clk); wait_engine(); seal_req = 1'b0;
    wait_grant(1'b0);
    for (int i = 4; i < 9; i++) cpu_write(8'h31 + 8'(i));
    @(negedge clk); wait_engine(); #1;
`ifdef CRC16_CTX_SAVE_EN
    chk("s6_resume_crc", cpu_crc, 16'h29B1);
    chk("s6_load_once", load_cnt, 1);
`else
    exp_crc = crc_byte(crc_byte(16'hFFFF, 8'h41), 8'h42);
    for (int i = 4; i < 9; i++) exp_crc = crc_byte(exp_crc, 8'h31 + 8'(i));
    chk("s6_continue_crc", cpu_crc, exp_crc);
`endif
    repeat (20) @(negedge clk);

    // reset asserted mid-SEAL
    seal_req = 1'b1;
    wait_grant(1'b1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      if (seal_ready) break;
    end
    chk("rs_in_seal", seal_ready, 1'b1);
    @(negedge clk);
    seal_valid = 1'b1; seal_data = 8'h77; cpu_data_valid = 1'b1; rst = 1'b1;
    #1;
    chk("rs_grant", seal_grant, 1'b0);
    chk("rs_ready", seal_ready, 1'b0);
    chk("rs_eng_init", eng_init, 1'b0);
    chk("rs_eng_dv", eng_data_valid, 1'b0);
    chk("rs_eng_data", eng_data, 8'h00);
    chk("rs_cpu_busy", cpu_busy, 1'b0);
`ifdef CRC16_CTX_SAVE_EN
    chk("rs_eng_load", eng_load, 1'b0);
`endif
    seal_req = 1'b0; seal_valid = 1'b0; cpu_data_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
